serial_descrambler: RTL and testbench

Self-synchronising serial descrambler. It is the receive-side inverse of the team's serial scrambler, using polynomial x^7 + x^6 + 1.
- Recovers the original bit stream from scrambled serial bits.
- Tracks synchronisation: the 7-bit history must hold received bits before output is valid.
- Assembles recovered bits into bytes for the downstream parallel link layer.

---
 rtl/serial_descrambler.sv | 111 +++++++++++
 tb/tb_serial_descrambler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_descrambler.sv
// rtl/serial_descrambler.sv - self-synchronising x^7+x^6+1 serial descrambler with byte assembly
module serial_descrambler #(
    parameter int PRESET_ALIGNED = 0,
    parameter int BYTE_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_scramble_data,
    input  logic              resync,
    output logic              out_valid,
    output logic              out_descramble_data,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_byte_valid,
    output logic              sync_locked
);

    localparam int IDX_W = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

    typedef enum logic {
        FILL   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [6:0]         d;
    logic [2:0]         fill_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [BYTE_W-1:0]  word;
    logic [BYTE_W-1:0]  word_next;
    logic               r;

    // Recovered bit uses the history of received (scrambled) bits, not recovered ones.
    assign r           = in_scramble_data ^ d[6] ^ d[5];
    assign sync_locked = (state == LOCKED);

    // State register; a preset-aligned far end means the history is already valid at reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (PRESET_ALIGNED != 0) ? LOCKED : FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: resync always wins; the seventh valid bit in FILL completes acquisition.
    always_comb begin
        state_next = state;
        if (resync) begin
            state_next = FILL;
        end else if (in_valid && (state == FILL) && (fill_cnt >= 3'd6)) begin
            state_next = LOCKED;
        end
    end

    // Word with the current recovered bit placed at its MSB-first position.
    always_comb begin
        word_next                     = word;
        word_next[LAST_IDX - bit_idx] = r;
    end

    // History, fill tracking, bit output and byte assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d                   <= 7'h7F;
            fill_cnt            <= 3'd0;
            bit_idx             <= '0;
            word                <= '0;
            out_valid           <= 1'b0;
            out_descramble_data <= 1'b0;
            out_byte            <= '0;
            out_byte_valid      <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            out_byte_valid <= 1'b0;
            if (resync) begin
                // History is kept; the partial word is dropped without a strobe.
                bit_idx <= '0;
                word    <= '0;
                if (in_valid) begin
                    d        <= {d[5:0], in_scramble_data};
                    fill_cnt <= 3'd1;
                end else begin
                    fill_cnt <= 3'd0;
                end
            end else if (in_valid) begin
                d <= {d[5:0], in_scramble_data};
                if (state == FILL) begin
                    if (fill_cnt != 3'd7) begin
                        fill_cnt <= fill_cnt + 3'd1;
                    end
                end else begin
                    out_valid           <= 1'b1;
                    out_descramble_data <= r;
                    if (bit_idx == LAST_IDX) begin
                        out_byte       <= word_next;
                        out_byte_valid <= 1'b1;
                        word           <= '0;
                        bit_idx        <= '0;
                    end else begin
                        word    <= word_next;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_descrambler.sv
// tb/tb_serial_descrambler.sv - scoreboard bench for serial_descrambler
module tb_serial_descrambler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: far end preset-aligned.  Instance f: acquires through FILL.
    logic       a_rn, a_iv, a_bit, a_rs;
    logic       a_ov, a_od, a_bv, a_lk;
    logic [7:0] a_byte;
    logic       f_rn, f_iv, f_bit, f_rs;
    logic       f_ov, f_od, f_bv, f_lk;
    logic [7:0] f_byte;

    serial_descrambler #(.PRESET_ALIGNED(1), .BYTE_W(8)) dut_a (
        .clk(clk), .rst_n(a_rn), .in_valid(a_iv), .in_scramble_data(a_bit), .resync(a_rs),
        .out_valid(a_ov), .out_descramble_data(a_od), .out_byte(a_byte),
        .out_byte_valid(a_bv), .sync_locked(a_lk)
    );

    serial_descrambler #(.PRESET_ALIGNED(0), .BYTE_W(8)) dut_f (
        .clk(clk), .rst_n(f_rn), .in_valid(f_iv), .in_scramble_data(f_bit), .resync(f_rs),
        .out_valid(f_ov), .out_descramble_data(f_od), .out_byte(f_byte),
        .out_byte_valid(f_bv), .sync_locked(f_lk)
    );

    int checks = 0;
    int errors = 0;

    logic q_bit_a[$];
    logic q_bit_f[$];
    logic [7:0] q_byte_a[$];
    logic [7:0] q_byte_f[$];

    logic a_last_iv = 1'b0;
    logic f_last_iv = 1'b0;
    logic [6:0] sd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // In_valid as seen by the edge that produces the next cycle's outputs.
    always @(posedge clk) begin
        a_last_iv = a_iv & a_rn;
        f_last_iv = f_iv & f_rn;
    end

    // Monitor: pop expectations whenever either instance presents an output.
    always @(negedge clk) begin
        if (!a_last_iv) check("a_ov_after_idle", a_ov, 0);
        if (!f_last_iv) check("f_ov_after_idle", f_ov, 0);
        if (a_ov) begin
            if (q_bit_a.size() == 0) check("a_bit_unexpected", 1, 0);
            else check("a_bit", a_od, q_bit_a.pop_front());
        end
        if (f_ov) begin
            if (q_bit_f.size() == 0) check("f_bit_unexpected", 1, 0);
            else check("f_bit", f_od, q_bit_f.pop_front());
        end
        if (a_bv) begin
            if (q_byte_a.size() == 0) check("a_byte_unexpected", 1, 0);
            else check("a_byte", a_byte, q_byte_a.pop_front());
        end
        if (f_bv) begin
            if (q_byte_f.size() == 0) check("f_byte_unexpected", 1, 0);
            else check("f_byte", f_byte, q_byte_f.pop_front());
        end
    end

    task automatic a_step(input logic iv, input logic b, input logic rs, input logic rn);
        a_iv = iv; a_bit = b; a_rs = rs; a_rn = rn;
        @(posedge clk); #1;
        a_iv = 1'b0; a_rs = 1'b0;
    endtask

    task automatic f_step(input logic iv, input logic b, input logic rs, input logic rn);
        f_iv = iv; f_bit = b; f_rs = rs; f_rn = rn;
        @(posedge clk); #1;
        f_iv = 1'b0; f_rs = 1'b0;
    endtask

    // Far-end scrambler: s = p ^ sd[6] ^ sd[5], history shifts in s.
    task automatic f_scr(input logic p, input logic push, input logic gaps, input logic rs);
        logic s;
        if (gaps && ($urandom_range(0, 9) < 3)) f_step(1'b0, 1'b0, 1'b0, 1'b1);
        s  = p ^ sd[6] ^ sd[5];
        sd = {sd[5:0], s};
        if (push) q_bit_f.push_back(p);
        f_step(1'b1, s, rs, 1'b1);
    endtask

    task automatic f_send_byte(input logic [7:0] v, input logic gaps);
        q_byte_f.push_back(v);
        for (int i = 7; i >= 0; i--) f_scr(v[i], 1'b1, gaps, 1'b0);
    endtask

    task automatic f_loopback(input logic [6:0] seed, input logic gaps);
        f_step(1'b0, 1'b0, 1'b0, 1'b0);
        sd = seed;
        for (int i = 0; i < 7; i++) f_scr(1'b0, 1'b0, gaps, 1'b0);
        f_send_byte(8'hA5, gaps);
        f_send_byte(8'h3C, gaps);
        f_send_byte(8'hFF, gaps);
        repeat (3) f_step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [7:0] t1_bits;

    initial begin
        a_rn = 1'b0; a_iv = 1'b0; a_bit = 1'b0; a_rs = 1'b0;
        f_rn = 1'b0; f_iv = 1'b0; f_bit = 1'b0; f_rs = 1'b0;
        t1_bits = 8'b0000_0010;
        repeat (2) @(posedge clk);
        #1;
        a_rn = 1'b1; f_rn = 1'b1;
        @(negedge clk);
        check("a_reset_ov", a_ov, 0);
        check("a_reset_od", a_od, 0);
        check("a_reset_byte", a_byte, 0);
        check("a_reset_bv", a_bv, 0);
        check("a_reset_locked", a_lk, 1);
        check("f_reset_ov", f_ov, 0);
        check("f_reset_byte", f_byte, 0);
        check("f_reset_locked", f_lk, 0);

        // Preset-aligned: 8 zeros give 0,0,0,0,0,0,1,0 -> 8'h02.
        for (int i = 7; i >= 0; i--) q_bit_a.push_back(t1_bits[i]);
        q_byte_a.push_back(8'h02);
        for (int i = 0; i < 8; i++) a_step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) a_step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-word: 3 bits of a word (history is all zero so they recover as 0).
        for (int i = 0; i < 3; i++) begin
            q_bit_a.push_back(1'b0);
            a_step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        a_step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("a_rst_ov", a_ov, 0);
        check("a_rst_od", a_od, 0);
        check("a_rst_byte", a_byte, 0);
        check("a_rst_bv", a_bv, 0);
        check("a_rst_locked", a_lk, 1);
        // Same 8 zeros again must reproduce 8'h02, proving history and index restarted.
        for (int i = 7; i >= 0; i--) q_bit_a.push_back(t1_bits[i]);
        q_byte_a.push_back(8'h02);
        for (int i = 0; i < 8; i++) a_step(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (2) a_step(1'b0, 1'b0, 1'b0, 1'b1);

        // FILL: 15 zeros; lock after bit 7, then one zero byte.
        for (int i = 1; i <= 15; i++) begin
            if (i > 7) q_bit_f.push_back(1'b0);
            if (i == 15) q_byte_f.push_back(8'h00);
            f_step(1'b1, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (i == 6) check("f_fill_locked_b6", f_lk, 0);
            if (i == 7) check("f_fill_locked_b7", f_lk, 1);
        end
        repeat (2) f_step(1'b0, 1'b0, 1'b0, 1'b1);

        // Loopback, contiguous then with random gaps.
        f_loopback(7'h35, 1'b0);
        f_loopback(7'h4B, 1'b1);

        // Resync on bit 3 of a word: bits 0..2 come out, the word never strobes.
        for (int i = 0; i < 3; i++) f_scr(1'b1, 1'b1, 1'b0, 1'b0);
        f_scr(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("f_resync_locked", f_lk, 0);
        check("f_resync_ov", f_ov, 0);
        check("f_resync_bv", f_bv, 0);
        for (int k = 1; k <= 6; k++) begin
            f_scr(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (k == 5) check("f_relock_b5", f_lk, 0);
            if (k == 6) check("f_relock_b6", f_lk, 1);
        end
        f_send_byte(8'h96, 1'b0);
        repeat (4) f_step(1'b0, 1'b0, 1'b0, 1'b1);

        check("a_bits_left", q_bit_a.size(), 0);
        check("a_bytes_left", q_byte_a.size(), 0);
        check("f_bits_left", q_bit_f.size(), 0);
        check("f_bytes_left", q_byte_f.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
